led_blink_arbiter: RTL and testbench
====================================

LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 12000000, clocks per blink phase; legal range >= 2.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 SHALL have parameter CW, default 4, width of each blink-count field.
REQ-004 CLK  input  1  system clock; all state updates on rising edge.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 REQ  input  NREQ  per-requester level request; held high until its ACK.
REQ-007 COUNT  input  NREQ*CW  packed blink counts; requester i uses bits [i*CW +: CW].
REQ-008 GRANT  output  NREQ  one-hot owner of the LED; all zero when idle.
REQ-009 ACK  output  NREQ  one-cycle completion pulse to the served requester.
REQ-010 BUSY  output  1  high whenever state is not IDLE.
REQ-011 LED  output  1  shared LED drive, registered.

Function
REQ-012 SHALL implement states IDLE, ON, OFF, GAP and DONE.
REQ-013 Phase counter SHALL count 0..CLK_DIV-1 and clear on every state change, so each ON, OFF or GAP phase lasts exactly CLK_DIV cycles.
REQ-014 In IDLE with any REQ high, SHALL grant the first requester with REQ high, searching upward from pointer PTR with wrap-around.
REQ-015 On grant, SHALL set GRANT one-hot and latch that requester's COUNT slice into a remaining counter REM.
REQ-016 On grant with latched count 0, SHALL go directly to DONE; LED stays 0.
REQ-017 On grant with latched count > 0, SHALL go to ON; LED goes high in the same cycle GRANT goes high.
REQ-018 ON SHALL drive LED=1, then go to OFF.
REQ-019 OFF SHALL drive LED=0; at phase end, decrement REM; go to ON if REM > 0 after the decrement, else go to GAP.
REQ-020 GAP SHALL drive LED=0, then go to DONE.
REQ-021 DONE SHALL last one cycle with ACK[owner]=1, GRANT still set and LED=0; the next state is IDLE with GRANT=0.
REQ-022 On leaving DONE, SHALL set PTR = owner+1, wrapping NREQ-1 to 0.
REQ-023 GRANT-high to ACK-high SHALL be exactly (2*N+1)*CLK_DIV cycles for latched count N > 0.
REQ-024 If REQ[owner] drops during ON, OFF or GAP, SHALL abort: next cycle IDLE, LED=0, GRANT=0, no ACK, PTR unchanged.
REQ-025 Changes to REQ or COUNT of non-owners during service SHALL be ignored.
REQ-026 Changes to the owner's COUNT after grant SHALL be ignored.
REQ-027 At least one IDLE cycle SHALL separate DONE and the next grant.
REQ-028 A requester still holding REQ after its ACK SHALL be re-served only after all other pending requesters, per REQ-014 and REQ-022.
REQ-029 ACK SHALL never be high in any cycle outside DONE.
REQ-030 At most one ACK bit and at most one GRANT bit SHALL be high in any cycle.
REQ-031 LED SHALL be 0 whenever GRANT is all zero.

Reset
REQ-032 RST high at an edge SHALL force the following registered values after that edge:
- state IDLE, PTR=0, REM=0, phase counter 0
- GRANT=0, ACK=0, BUSY=0, LED=0
REQ-033 Reset SHALL take effect mid-service and SHALL take priority over all other inputs.
REQ-034 No ACK SHALL be issued for a service aborted by reset.

Verification (CLK_DIV=6, NREQ=4, CW=4)
REQ-035 Bench SHALL cover a single request: REQ=0001, COUNT[3:0]=2 -> GRANT=0001, LED 1 for 6 cycles, 0 for 6, 1 for 6, 0 for 12; ACK=0001 for one cycle 30 cycles after GRANT rises; then BUSY=0.
REQ-036 Bench SHALL cover round-robin with REQ=1111 held, all counts 1: grants in order 0001, 0010, 0100, 1000, 0001, ..., each 18 cycles GRANT to ACK, with exactly one IDLE cycle between services.
REQ-037 Bench SHALL cover zero count: REQ=0100, COUNT[11:8]=0 -> GRANT=0100 and ACK=0100 together for one cycle, LED=0 throughout.
REQ-038 Bench SHALL cover abort: REQ=0010, count 3, REQ dropped during the second ON phase -> next cycle LED=0, GRANT=0, BUSY=0, no ACK; a later REQ=1010 grants 0010 first, since PTR was not advanced.
REQ-039 Bench SHALL cover reset during an OFF phase -> after the reset edge all outputs are 0; with REQ=1111 afterwards, the first grant is 0001.
REQ-040 Throughout all scenarios, the bench SHALL check every cycle that GRANT and ACK are each one-hot or zero and that LED=1 implies GRANT is non-zero.

Source files
------------

// File: rtl/led_blink_arbiter.sv
`default_nettype none
// led_blink_arbiter: round-robin arbiter that lends one shared LED to NREQ
// requesters, blinking it COUNT times per grant before acknowledging.
module led_blink_arbiter #(
   parameter int CLK_DIV = 12000000,
   parameter int NREQ    = 4,
   parameter int CW      = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*CW-1:0] COUNT,
   output logic [NREQ-1:0]    GRANT,
   output logic [NREQ-1:0]    ACK,
   output logic               BUSY,
   output logic               LED
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ON   = 3'd1,
      S_OFF  = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [PW-1:0]     phase, phase_n;
   logic [CW-1:0]     rem, rem_n;
   logic [IW-1:0]     ptr, ptr_n;
   logic [IW-1:0]     owner, owner_n;
   logic [NREQ-1:0]   grant, grant_n;
   logic [NREQ-1:0]   ack, ack_n;
   logic              led, led_n;

   logic              found;
   logic [IW-1:0]     pick;
   int                idx;
   logic              phase_end;
   logic              owner_req;

   // First pending requester at or above ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && REQ[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   assign phase_end = (phase == PW'(CLK_DIV - 1));
   assign owner_req = REQ[owner];

   always_comb begin
      state_n = state;
      phase_n = phase + PW'(1);
      rem_n   = rem;
      ptr_n   = ptr;
      owner_n = owner;
      grant_n = grant;
      ack_n   = '0;
      led_n   = led;

      case (state)
         S_IDLE: begin
            phase_n = '0;
            if (found) begin
               owner_n = pick;
               grant_n = NREQ'(1) << pick;
               rem_n   = COUNT[int'(pick)*CW +: CW];
               if (rem_n == '0) begin
                  state_n = S_DONE;
                  ack_n   = NREQ'(1) << pick;
               end else begin
                  state_n = S_ON;
                  led_n   = 1'b1;
               end
            end
         end

         S_ON, S_OFF, S_GAP: begin
            // A dropped owner request wins over any phase boundary.
            if (!owner_req) begin
               state_n = S_IDLE;
               phase_n = '0;
               grant_n = '0;
               led_n   = 1'b0;
            end else if (phase_end) begin
               phase_n = '0;
               if (state == S_ON) begin
                  state_n = S_OFF;
                  led_n   = 1'b0;
               end else if (state == S_OFF) begin
                  rem_n = rem - CW'(1);
                  if (rem_n != '0) begin
                     state_n = S_ON;
                     led_n   = 1'b1;
                  end else begin
                     state_n = S_GAP;
                  end
               end else begin
                  state_n = S_DONE;
                  ack_n   = grant;
               end
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
            phase_n = '0;
            grant_n = '0;
            led_n   = 1'b0;
            ptr_n   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
         end

         default: begin
            state_n = S_IDLE;
            phase_n = '0;
            grant_n = '0;
            led_n   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         phase <= '0;
         rem   <= '0;
         ptr   <= '0;
         owner <= '0;
         grant <= '0;
         ack   <= '0;
         led   <= 1'b0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         rem   <= rem_n;
         ptr   <= ptr_n;
         owner <= owner_n;
         grant <= grant_n;
         ack   <= ack_n;
         led   <= led_n;
      end
   end

   assign GRANT = grant;
   assign ACK   = ack;
   assign LED   = led;
   assign BUSY  = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_blink_arbiter.sv
`default_nettype none
// tb_led_blink_arbiter: scoreboard bench; each expected service is queued when
// its request is driven and retired when the DUT grants, blinks and acks it.
module tb_led_blink_arbiter;

   localparam int CLK_DIV = 6;
   localparam int NREQ    = 4;
   localparam int CW      = 4;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic [NREQ-1:0]    REQ = '0;
   logic [NREQ*CW-1:0] COUNT = '0;
   logic [NREQ-1:0]    GRANT;
   logic [NREQ-1:0]    ACK;
   logic               BUSY;
   logic               LED;

   led_blink_arbiter #(.CLK_DIV(CLK_DIV), .NREQ(NREQ), .CW(CW)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .REQ   (REQ),
      .COUNT (COUNT),
      .GRANT (GRANT),
      .ACK   (ACK),
      .BUSY  (BUSY),
      .LED   (LED)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [NREQ-1:0] grant;
      int              n;
      bit              abort;
      bit              chk_gap;
   } svc_t;

   svc_t            sb[$];
   svc_t            cur;
   int              n_cmp = 0;
   int              n_err = 0;
   int              cyc = 0;
   int              t0 = 0;
   int              last_ack = 0;
   int              off = 0;
   bit              in_svc = 1'b0;
   bit              acked = 1'b0;
   bit              led_exp;
   logic [NREQ-1:0] prev_grant = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void expect_svc(input logic [NREQ-1:0] g, input int n,
                                      input bit ab, input bit gap);
      svc_t s;
      s.grant = g; s.n = n; s.abort = ab; s.chk_gap = gap;
      sb.push_back(s);
   endfunction

   task automatic wait_ack(input int limit);
      bit got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (ACK != '0) begin got = 1'b1; break; end
      end
      check("ack_wait", {31'd0, got}, 32'd1);
   endtask

   task automatic wait_grant(input int limit);
      bit got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (GRANT != '0) begin got = 1'b1; break; end
      end
      check("grant_wait", {31'd0, got}, 32'd1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_grant"}, {28'd0, GRANT}, 32'd0);
      check({tag, "_ack"},   {28'd0, ACK},   32'd0);
      check({tag, "_busy"},  {31'd0, BUSY},  32'd0);
      check({tag, "_led"},   {31'd0, LED},   32'd0);
   endtask

   // Monitor: per-cycle invariants plus scoreboard retirement.
   initial begin
      forever begin
         @(negedge CLK);
         cyc++;
         check("grant_onehot0", {31'd0, $onehot0(GRANT)}, 32'd1);
         check("ack_onehot0",   {31'd0, $onehot0(ACK)},   32'd1);
         check("led_without_grant", {31'd0, (LED && GRANT == '0)}, 32'd0);
         check("busy_vs_grant", {31'd0, BUSY}, {31'd0, (GRANT != '0)});
         if (GRANT != '0 && prev_grant == '0) begin
            if (sb.size() == 0) begin
               check("unexpected_grant", {28'd0, GRANT}, 32'd0);
            end else begin
               cur = sb.pop_front();
               check("grant_owner", {28'd0, GRANT}, {28'd0, cur.grant});
               if (cur.chk_gap) check("idle_gap", cyc - last_ack, 32'd2);
               in_svc = 1'b1;
               acked  = 1'b0;
               t0     = cyc;
            end
         end
         if (in_svc && GRANT != '0) begin
            off     = cyc - t0;
            led_exp = (off < 2*CLK_DIV*cur.n) && (((off / CLK_DIV) % 2) == 0);
            check("led_pattern", {31'd0, LED}, {31'd0, led_exp});
         end
         if (ACK != '0) begin
            check("ack_owner", {28'd0, ACK}, {28'd0, (in_svc ? cur.grant : 4'd0)});
            check("ack_latency", cyc - t0, (cur.n == 0) ? 0 : (2*cur.n + 1)*CLK_DIV);
            acked    = 1'b1;
            last_ack = cyc;
         end
         if (GRANT == '0 && prev_grant != '0 && in_svc) begin
            check("ack_issued", {31'd0, acked}, {31'd0, !cur.abort});
            in_svc = 1'b0;
         end
         prev_grant = GRANT;
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge CLK);
      check_quiet("reset");
      RST = 1'b0;

      // Single requester, two blinks
      expect_svc(4'b0001, 2, 1'b0, 1'b0);
      COUNT = 16'h0002;
      REQ   = 4'b0001;
      wait_ack(200);
      REQ = 4'b0000;
      repeat (2) @(negedge CLK);
      check_quiet("single_after");

      // Abort during second ON phase; ptr stays at 1
      expect_svc(4'b0010, 3, 1'b1, 1'b0);
      COUNT = 16'h0030;
      REQ   = 4'b0010;
      wait_grant(50);
      repeat (14) @(negedge CLK);
      REQ = 4'b0000;
      @(negedge CLK);
      check_quiet("abort_after");

      // Requester 1 is served first because the abort left ptr alone
      expect_svc(4'b0010, 1, 1'b0, 1'b0);
      expect_svc(4'b1000, 1, 1'b0, 1'b1);
      COUNT = 16'h1010;
      REQ   = 4'b1010;
      wait_ack(100);
      REQ = 4'b1000;
      wait_ack(100);
      REQ = 4'b0000;
      repeat (2) @(negedge CLK);

      // Zero count: grant and ack in the same cycle, LED dark
      expect_svc(4'b0100, 0, 1'b0, 1'b0);
      COUNT = 16'h0000;
      REQ   = 4'b0100;
      wait_ack(50);
      REQ = 4'b0000;
      repeat (2) @(negedge CLK);
      check_quiet("zero_after");

      // Reset during OFF of the 1000 service, then round robin from 0001
      expect_svc(4'b1000, 1, 1'b1, 1'b0);
      expect_svc(4'b0001, 1, 1'b0, 1'b0);
      expect_svc(4'b0010, 1, 1'b0, 1'b1);
      expect_svc(4'b0100, 1, 1'b0, 1'b1);
      expect_svc(4'b1000, 1, 1'b0, 1'b1);
      expect_svc(4'b0001, 1, 1'b0, 1'b1);
      COUNT = 16'h1111;
      REQ   = 4'b1111;
      wait_grant(50);
      repeat (8) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check_quiet("midreset");
      RST = 1'b0;
      for (int s = 0; s < 5; s++) wait_ack(100);
      REQ = 4'b0000;
      repeat (3) @(negedge CLK);
      check_quiet("rr_after");
      check("scoreboard_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
